// File: rtl/sp_ram_be_if.sv
// Request/response bundle for sp_ram_be: the requester owns the master side,
// the RAM owns the slave side.
interface sp_ram_be_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256
);
    localparam int NB     = DATA_WIDTH / 8;
    localparam int ADDR_W = $clog2(DEPTH);

    logic                  wr_en;
    logic                  rd_en;
    logic [ADDR_W-1:0]     addr;
    logic [NB-1:0]         be;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  rd_valid;
    logic                  busy;

    modport master (
        output wr_en, rd_en, addr, be, data_in,
        input  data_out, rd_valid, busy
    );

    modport slave (
        input  wr_en, rd_en, addr, be, data_in,
        output data_out, rd_valid, busy
    );
endinterface

// File: rtl/sp_ram_be.sv
// Single-port synchronous RAM with byte enables, selectable read-during-write
// behaviour, optional output register and an optional post-reset clear pass.
module sp_ram_be #(
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 256,
    parameter int RDW_MODE       = 0,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic        clk,
    input  logic        rst,
    sp_ram_be_if.slave  bus
);
    localparam int NB     = DATA_WIDTH / 8;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int STAGES = OUT_REG;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                state, state_nx;
    logic [ADDR_W-1:0]     clr_addr;
    logic                  clr_last;
    logic                  busy;
    logic                  accept, in_range, wr_fire, rd_fire;

    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [NB-1:0]         mem_be;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DATA_WIDTH-1:0] ram_q, wdat_q, word1;
    logic [NB-1:0]         be_q;
    logic                  wf_q, oor_q;
    logic [STAGES:0]       vld_pipe;

    assign busy     = (state == CLEAR);
    assign clr_last = (int'(clr_addr) == DEPTH - 1);
    assign in_range = (int'(bus.addr) < DEPTH);
    assign accept   = ~busy & ~rst;
    assign wr_fire  = accept & bus.wr_en & in_range;
    // In no-change mode a combined read+write produces no read at all.
    assign rd_fire  = accept & bus.rd_en & ~(bus.wr_en && (RDW_MODE == 2));

    always_ff @(posedge clk) begin
        if (rst) state <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
        else     state <= state_nx;
    end

    // The clear sequencer borrows the single write port while it runs.
    always_comb begin
        state_nx  = state;
        mem_we    = wr_fire;
        mem_addr  = bus.addr;
        mem_be    = bus.be;
        mem_wdata = bus.data_in;
        case (state)
            CLEAR: begin
                mem_we    = ~rst;
                mem_addr  = clr_addr;
                mem_be    = '1;
                mem_wdata = '0;
                if (clr_last) state_nx = IDLE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)       clr_addr <= '0;
        else if (busy) clr_addr <= clr_last ? '0 : clr_addr + ADDR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++)
                if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
    end

    // Read port is always read-first; write-first data is merged after the
    // RAM output so the array itself stays a plain block RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_q  <= '0;
            wdat_q <= '0;
            be_q   <= '0;
            wf_q   <= 1'b0;
            oor_q  <= 1'b0;
        end else if (rd_fire) begin
            ram_q  <= mem[bus.addr];
            wdat_q <= bus.data_in;
            be_q   <= bus.be;
            wf_q   <= bus.wr_en && (RDW_MODE == 1);
            oor_q  <= ~in_range;
        end
    end

    always_comb begin
        word1 = ram_q;
        for (int i = 0; i < NB; i++)
            if (wf_q && be_q[i]) word1[8*i +: 8] = wdat_q[8*i +: 8];
        if (oor_q) word1 = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= rd_fire;
            for (int s = 1; s <= STAGES; s++) vld_pipe[s] <= vld_pipe[s-1];
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DATA_WIDTH-1:0] dout_r;
            always_ff @(posedge clk) begin
                if (rst)              dout_r <= '0;
                else if (vld_pipe[0]) dout_r <= word1;
            end
            assign bus.data_out = dout_r;
        end else begin : g_noreg
            assign bus.data_out = word1;
        end
    endgenerate

    assign bus.rd_valid = vld_pipe[STAGES];
    assign bus.busy     = busy;
endmodule

// File: tb/tb_sp_ram_be.sv
// Three sp_ram_be variants driven in lockstep and checked against an
// array-based behavioural model plus directed tables and sequences.
module tb_sp_ram_be;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sp_ram_be_if #(.DATA_WIDTH(32), .DEPTH(16)) if0 ();
    sp_ram_be_if #(.DATA_WIDTH(32), .DEPTH(12)) if1 ();
    sp_ram_be_if #(.DATA_WIDTH(32), .DEPTH(12)) if2 ();

    sp_ram_be #(.DATA_WIDTH(32), .DEPTH(16), .RDW_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1))
        u0 (.clk(clk), .rst(rst), .bus(if0));
    sp_ram_be #(.DATA_WIDTH(32), .DEPTH(12), .RDW_MODE(1), .OUT_REG(1), .CLEAR_ON_RESET(1))
        u1 (.clk(clk), .rst(rst), .bus(if1));
    sp_ram_be #(.DATA_WIDTH(32), .DEPTH(12), .RDW_MODE(2), .OUT_REG(0), .CLEAR_ON_RESET(1))
        u2 (.clk(clk), .rst(rst), .bus(if2));

    logic [31:0] dout [3];
    logic        vld  [3];
    logic        bsy  [3];
    always_comb begin
        dout[0] = if0.data_out; vld[0] = if0.rd_valid; bsy[0] = if0.busy;
        dout[1] = if1.data_out; vld[1] = if1.rd_valid; bsy[1] = if1.busy;
        dout[2] = if2.data_out; vld[2] = if2.rd_valid; bsy[2] = if2.busy;
    end

    int depk [3] = '{16, 12, 12};
    int rdwk [3] = '{0, 1, 2};
    int latk [3] = '{1, 2, 1};

    // Model state: memory contents, remaining clear cycles, and a calendar of
    // read results keyed by the edge on which they must appear.
    logic [31:0] mmem  [3][16];
    int          mcnt  [3];
    logic        cal_v [3][4];
    logic [31:0] cal_d [3][4];
    logic [31:0] mdata [3];
    int ecount = 0;
    int nvec   = 0;
    int nfail  = 0;

    typedef struct {
        logic        w;
        logic        rd;
        logic [3:0]  a;
        logic [3:0]  b;
        logic [31:0] d;
        logic        ev;
        logic [31:0] edout;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge(input int k, input logic r, input logic w, input logic rd,
                              input logic [3:0] a, input logic [3:0] b, input logic [31:0] d);
        logic [31:0] old, mrg;
        bit inr;
        int slot;
        if (r) begin
            mcnt[k] = depk[k];
            for (int s = 0; s < 4; s++) cal_v[k][s] = 1'b0;
            mdata[k] = '0;
        end else if (mcnt[k] > 0) begin
            mmem[k][depk[k] - mcnt[k]] = '0;
            mcnt[k]--;
        end else begin
            inr = (int'(a) < depk[k]);
            old = inr ? mmem[k][a] : 32'h0;
            mrg = old;
            for (int i = 0; i < 4; i++) if (b[i]) mrg[8*i +: 8] = d[8*i +: 8];
            if (w && inr) mmem[k][a] = mrg;
            if (rd && !(w && rdwk[k] == 2)) begin
                slot = (ecount + latk[k] - 1) % 4;
                cal_v[k][slot] = 1'b1;
                cal_d[k][slot] = (w && rdwk[k] == 1) ? (inr ? mrg : 32'h0) : old;
            end
        end
    endtask

    task automatic step(input logic r, input logic w, input logic rd,
                        input logic [3:0] a, input logic [3:0] b, input logic [31:0] d);
        logic ev;
        rst = r;
        if0.wr_en = w; if0.rd_en = rd; if0.addr = a; if0.be = b; if0.data_in = d;
        if1.wr_en = w; if1.rd_en = rd; if1.addr = a; if1.be = b; if1.data_in = d;
        if2.wr_en = w; if2.rd_en = rd; if2.addr = a; if2.be = b; if2.data_in = d;
        @(posedge clk);
        ecount++;
        for (int k = 0; k < 3; k++) model_edge(k, r, w, rd, a, b, d);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            ev = cal_v[k][ecount % 4];
            if (ev) begin
                mdata[k] = cal_d[k][ecount % 4];
                cal_v[k][ecount % 4] = 1'b0;
            end
            chk($sformatf("model u%0d rd_valid", k), 32'(vld[k]), 32'(ev));
            chk($sformatf("model u%0d data_out", k), dout[k], mdata[k]);
            chk($sformatf("model u%0d busy", k), 32'(bsy[k]), 32'(mcnt[k] > 0));
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, n1;
        for (int k = 0; k < 3; k++) begin
            mcnt[k] = 0; mdata[k] = '0;
            for (int s = 0; s < 4; s++) begin cal_v[k][s] = 1'b0; cal_d[k][s] = '0; end
            for (int i = 0; i < 16; i++) mmem[k][i] = '0;
        end

        tbl[0] = '{1'b1, 1'b0, 4'd5, 4'hF, 32'hAABBCCDD, 1'b0, 32'h00000000};
        tbl[1] = '{1'b1, 1'b0, 4'd5, 4'h5, 32'h11223344, 1'b0, 32'h00000000};
        tbl[2] = '{1'b0, 1'b1, 4'd5, 4'h0, 32'h0,        1'b1, 32'hAA22CC44};
        tbl[3] = '{1'b0, 1'b0, 4'd0, 4'h0, 32'h0,        1'b0, 32'hAA22CC44};
        tbl[4] = '{1'b1, 1'b1, 4'd3, 4'h3, 32'h12345678, 1'b1, 32'h00000000};
        tbl[5] = '{1'b0, 1'b1, 4'd3, 4'h0, 32'h0,        1'b1, 32'h00005678};
        tbl[6] = '{1'b1, 1'b0, 4'd3, 4'h0, 32'hFFFFFFFF, 1'b0, 32'h00005678};
        tbl[7] = '{1'b0, 1'b1, 4'd3, 4'h0, 32'h0,        1'b1, 32'h00005678};

        // Power-up reset and initial clear
        step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 32'h0);
        for (int c = 0; c < 40 && (bsy[0] || bsy[1] || bsy[2]); c++) idle();
        chk("initial clear done", 32'(bsy[0] | bsy[1] | bsy[2]), 32'h0);

        // Clear sequence length after a 2-cycle reset pulse
        for (int a = 0; a < 16; a++) step(1'b0, 1'b1, 1'b0, 4'(a), 4'hF, 32'hFFFFFFFF);
        step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 32'h0);
        n0 = 0; n1 = 0;
        for (int c = 0; c < 40; c++) begin
            if (bsy[0]) n0++;
            if (bsy[1]) n1++;
            idle();
        end
        chk("busy cycles depth16", 32'(n0), 32'd16);
        chk("busy cycles depth12", 32'(n1), 32'd12);
        for (int a = 0; a < 16; a++) step(1'b0, 1'b0, 1'b1, 4'(a), 4'd0, 32'h0);

        // Byte enables and read-during-write table (expectations for u0)
        for (int i = 0; i < 8; i++) begin
            step(1'b0, tbl[i].w, tbl[i].rd, tbl[i].a, tbl[i].b, tbl[i].d);
            chk($sformatf("tbl[%0d] rd_valid", i), 32'(vld[0]), 32'(tbl[i].ev));
            chk($sformatf("tbl[%0d] data_out", i), dout[0], tbl[i].edout);
        end

        // Reset at clear cycle 7, write attempted while busy
        step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 32'h0);
        for (int c = 0; c < 7; c++) idle();
        step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 32'h0);
        n0 = 0;
        for (int c = 0; c < 40; c++) begin
            if (bsy[0]) n0++;
            if (c == 3) step(1'b0, 1'b1, 1'b0, 4'd2, 4'hF, 32'hDEADBEEF);
            else        idle();
        end
        chk("busy cycles after mid-clear reset", 32'(n0), 32'd16);
        step(1'b0, 1'b0, 1'b1, 4'd2, 4'd0, 32'h0);
        chk("ignored write rd_valid", 32'(vld[0]), 32'd1);
        chk("ignored write data", dout[0], 32'h0);

        // Streaming reads
        for (int a = 0; a < 16; a++) step(1'b0, 1'b1, 1'b0, 4'(a), 4'hF, 32'(a));
        for (int a = 0; a < 16; a++) begin
            step(1'b0, 1'b0, 1'b1, 4'(a), 4'd0, 32'h0);
            chk("stream u0 rd_valid", 32'(vld[0]), 32'd1);
            chk("stream u0 data", dout[0], 32'(a));
            if (a > 0) begin
                chk("stream u1 rd_valid", 32'(vld[1]), 32'd1);
                chk("stream u1 data", dout[1], (a - 1 < 12) ? 32'(a - 1) : 32'h0);
            end
        end
        idle();
        chk("stream end u0 rd_valid", 32'(vld[0]), 32'd0);

        // Out-of-range access on the 12-deep, 2-cycle-latency variant
        step(1'b0, 1'b1, 1'b0, 4'd13, 4'hF, 32'hCAFEF00D);
        step(1'b0, 1'b0, 1'b1, 4'd11, 4'd0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 4'd13, 4'd0, 32'h0);
        chk("oor prior u1 data", dout[1], 32'd11);
        idle();
        chk("oor u1 rd_valid", 32'(vld[1]), 32'd1);
        chk("oor u1 data", dout[1], 32'h0);
        idle();
        chk("oor idle u1 rd_valid", 32'(vld[1]), 32'd0);
        chk("oor idle u1 data", dout[1], 32'h0);

        // Randomised traffic with occasional resets
        for (int c = 0; c < 500; c++)
            step($urandom_range(0, 99) == 0, 1'($urandom), 1'($urandom),
                 4'($urandom_range(0, 15)), 4'($urandom), $urandom);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
